// File: rtl/tx_byte_ctrl.sv
// Byte transmit sequencer for the serial shift register; TX_BYTE_CTRL_TIMEOUT_EN adds a no-edge watchdog.
// Load strobe 1 cycle after accept, outputs registered; byte_ready only while idle, host holds byte_valid.
module tx_byte_ctrl #(
  parameter int BYTE_WIDTH     = 8,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  falling_edge_found,
  input  logic                  rising_edge_found,
  input  logic                  sda_in,
  input  logic                  abort,
  input  logic                  byte_valid,
  input  logic [BYTE_WIDTH-1:0] byte_data,
  output logic                  byte_ready,
  output logic [BYTE_WIDTH-1:0] tx_data,
  output logic                  load_data,
  output logic                  tx_enable,
  output logic                  sda_oe,
  output logic                  ack_rcvd,
  output logic                  nack_rcvd,
  output logic                  timeout,
  output logic                  busy
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    LOAD     = 3'd1,
    SHIFT    = 3'd2,
    ACK_WAIT = 3'd3,
    ACK_END  = 3'd4
  } state_t;

  localparam int CNT_W = (BYTE_WIDTH > 1) ? $clog2(BYTE_WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(BYTE_WIDTH - 1);

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] bit_cnt;
  logic [CNT_W-1:0] bit_cnt_nxt;
  logic             accept;
  logic             ack_nxt;
  logic             nack_nxt;
  logic             timeout_nxt;

`ifdef TX_BYTE_CTRL_TIMEOUT_EN
  localparam int WD_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

  logic [WD_W-1:0] wd_cnt;
  logic            wd_active;
  logic            any_edge;
  logic            wd_expire;

  assign wd_active = (state == SHIFT) || (state == ACK_WAIT) || (state == ACK_END);
  assign any_edge  = falling_edge_found | rising_edge_found;
  // An edge arriving on the terminal count still counts as activity.
  assign wd_expire = wd_active && !any_edge && (wd_cnt == WD_LAST);
`endif

  assign accept = (state == IDLE) && byte_valid && !abort;

  always_comb begin
    state_nxt   = state;
    bit_cnt_nxt = bit_cnt;
    ack_nxt     = 1'b0;
    nack_nxt    = 1'b0;
    timeout_nxt = 1'b0;
    if (abort) begin
      state_nxt = IDLE;
    end
`ifdef TX_BYTE_CTRL_TIMEOUT_EN
    else if (wd_expire) begin
      state_nxt   = IDLE;
      timeout_nxt = 1'b1;
    end
`endif
    else begin
      case (state)
        IDLE: begin
          if (accept) state_nxt = LOAD;
        end
        LOAD: begin
          bit_cnt_nxt = '0;
          state_nxt   = SHIFT;
        end
        SHIFT: begin
          if (falling_edge_found) begin
            // Counter parks on the last bit instead of wrapping.
            if (bit_cnt == LAST_BIT) state_nxt = ACK_WAIT;
            else                     bit_cnt_nxt = bit_cnt + 1'b1;
          end
        end
        ACK_WAIT: begin
          if (rising_edge_found) begin
            ack_nxt   = ~sda_in;
            nack_nxt  = sda_in;
            state_nxt = ACK_END;
          end
        end
        ACK_END: begin
          if (falling_edge_found) state_nxt = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Moore outputs are decoded from the next state so they line up with the state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      bit_cnt    <= '0;
      tx_data    <= '0;
      byte_ready <= 1'b1;
      load_data  <= 1'b0;
      tx_enable  <= 1'b0;
      sda_oe     <= 1'b0;
      ack_rcvd   <= 1'b0;
      nack_rcvd  <= 1'b0;
      timeout    <= 1'b0;
      busy       <= 1'b0;
`ifdef TX_BYTE_CTRL_TIMEOUT_EN
      wd_cnt     <= '0;
`endif
    end else begin
      state      <= state_nxt;
      bit_cnt    <= bit_cnt_nxt;
      if (accept) tx_data <= byte_data;
      byte_ready <= (state_nxt == IDLE);
      load_data  <= (state_nxt == LOAD);
      tx_enable  <= (state_nxt == SHIFT);
      sda_oe     <= (state_nxt == SHIFT);
      ack_rcvd   <= ack_nxt;
      nack_rcvd  <= nack_nxt;
      timeout    <= timeout_nxt;
      busy       <= (state_nxt != IDLE);
`ifdef TX_BYTE_CTRL_TIMEOUT_EN
      if (!wd_active || any_edge || (state_nxt != state)) wd_cnt <= '0;
      else                                                 wd_cnt <= wd_cnt + 1'b1;
`endif
    end
  end

endmodule

// File: tb/tb_tx_byte_ctrl.sv
// Directed bench for tx_byte_ctrl: transaction-level model compared every cycle plus literal pins.
module tb_tx_byte_ctrl;
  localparam int BW = 8;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          fe = 1'b0;
  logic          re = 1'b0;
  logic          sda_in = 1'b1;
  logic          abort = 1'b0;
  logic          byte_valid = 1'b0;
  logic [BW-1:0] byte_data = '0;
  logic          byte_ready, load_data, tx_enable, sda_oe;
  logic          ack_rcvd, nack_rcvd, timeout, busy;
  logic [BW-1:0] tx_data;

  always #5 clk = ~clk;

  tx_byte_ctrl #(.BYTE_WIDTH(BW), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst),
    .falling_edge_found(fe), .rising_edge_found(re),
    .sda_in(sda_in), .abort(abort),
    .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(byte_ready),
    .tx_data(tx_data), .load_data(load_data), .tx_enable(tx_enable), .sda_oe(sda_oe),
    .ack_rcvd(ack_rcvd), .nack_rcvd(nack_rcvd), .timeout(timeout), .busy(busy)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: which phase of a byte transfer we are in, how many bits have gone out,
  // and how long the line has been quiet. Cycle k is the cycle after k posedges.
  localparam int P_IDLE = 0, P_LOAD = 1, P_SHIFT = 2, P_ACKW = 3, P_ACKE = 4;
  int            m_phase = P_IDLE;
  int            m_bits = 0;
  int            m_quiet = 0;
  logic [BW-1:0] m_data = '0;
  bit            m_ack = 0, m_nack = 0, m_to = 0, m_live = 0;
  int            cyc = 0, last_fe_cyc = 0, n_shift_fe = 0;
  int            n_ack = 0, n_nack = 0, n_to = 0;

  always @(posedge clk) begin
    int  prev;
    bit  edge_seen;
    bit  expire;
    if (fe) last_fe_cyc = cyc;
    if (fe && tx_enable) n_shift_fe++;
    cyc++;
    prev      = m_phase;
    edge_seen = fe || re;
    m_ack = 0; m_nack = 0; m_to = 0;
`ifdef TX_BYTE_CTRL_TIMEOUT_EN
    expire = (prev >= P_SHIFT) && !edge_seen && (m_quiet == TO - 1);
`else
    expire = 0;
`endif
    if (rst) begin
      m_phase = P_IDLE; m_data = '0; m_live = 1;
    end else if (abort) begin
      m_phase = P_IDLE;
    end else if (expire) begin
      m_phase = P_IDLE; m_to = 1;
    end else begin
      case (m_phase)
        P_IDLE:  if (byte_valid) begin m_data = byte_data; m_phase = P_LOAD; end
        P_LOAD:  begin m_bits = 0; m_phase = P_SHIFT; end
        P_SHIFT: if (fe) begin m_bits++; if (m_bits == BW) m_phase = P_ACKW; end
        P_ACKW:  if (re) begin m_ack = !sda_in; m_nack = sda_in; m_phase = P_ACKE; end
        P_ACKE:  if (fe) m_phase = P_IDLE;
        default: m_phase = P_IDLE;
      endcase
    end
    m_quiet = (m_phase != prev || edge_seen || prev < P_SHIFT) ? 0 : m_quiet + 1;
  end

  always @(negedge clk) begin
    if (m_live) begin
      if (ack_rcvd) n_ack++;
      if (nack_rcvd) n_nack++;
      if (timeout) n_to++;
      chk("byte_ready", byte_ready, m_phase == P_IDLE);
      chk("load_data", load_data, m_phase == P_LOAD);
      chk("tx_enable", tx_enable, m_phase == P_SHIFT);
      chk("sda_oe", sda_oe, m_phase == P_SHIFT);
      chk("busy", busy, m_phase != P_IDLE);
      chk("ack_rcvd", ack_rcvd, m_ack);
      chk("nack_rcvd", nack_rcvd, m_nack);
      chk("timeout", timeout, m_to);
      chk("tx_data", tx_data, m_data);
    end
  end

  // All drivers below start and end on a negedge.
  task automatic fall();
    fe = 1'b1; @(negedge clk); fe = 1'b0; @(negedge clk);
  endtask

  task automatic rise();
    re = 1'b1; @(negedge clk); re = 1'b0; @(negedge clk);
  endtask

  task automatic shift_bits(input int n);
    for (int i = 0; i < n; i++) begin rise(); fall(); end
  endtask

  task automatic ack_slot(input logic bit_val);
    sda_in = bit_val; rise(); sda_in = 1'b1;
  endtask

  task automatic wait_load(input string name, input int lim);
    bit ok;
    ok = 0;
    for (int i = 0; i < lim && !ok; i++) begin
      @(negedge clk);
      if (load_data) ok = 1;
    end
    chk(name, ok, 1);
  endtask

  initial begin
    int a0, k0, s0, t0, gap;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("reset_byte_ready", byte_ready, 1);
    chk("reset_busy", busy, 0);
    chk("reset_tx_data", tx_data, 8'h00);
    chk("reset_tx_enable", tx_enable, 0);

    // Single byte with ACK; includes a stray falling edge in the ACK slot.
    a0 = n_ack; k0 = n_nack;
    byte_data = 8'hA5; byte_valid = 1'b1;
    wait_load("a5_load_seen", 8);
    chk("a5_tx_data", tx_data, 8'hA5);
    byte_valid = 1'b0;
    @(negedge clk);
    chk("a5_load_one_cycle", load_data, 0);
    chk("a5_shift_start", tx_enable, 1);
    s0 = n_shift_fe;
    shift_bits(8);
    chk("a5_shift_edges", n_shift_fe - s0, 8);
    chk("a5_line_released", sda_oe, 0);
    fall();
    ack_slot(1'b0);
    fall();
    chk("a5_ack_count", n_ack - a0, 1);
    chk("a5_nack_count", n_nack - k0, 0);
    chk("a5_idle", byte_ready, 1);

    // NACK.
    a0 = n_ack; k0 = n_nack;
    byte_data = 8'h3C; byte_valid = 1'b1;
    wait_load("3c_load_seen", 8);
    byte_valid = 1'b0;
    shift_bits(8);
    ack_slot(1'b1);
    fall();
    chk("3c_nack_count", n_nack - k0, 1);
    chk("3c_ack_count", n_ack - a0, 0);
    chk("3c_idle", busy, 0);

    // Back-to-back with byte_valid held.
    byte_data = 8'h01; byte_valid = 1'b1;
    wait_load("b2b_first_load", 8);
    chk("b2b_first_data", tx_data, 8'h01);
    byte_data = 8'hFF;
    shift_bits(8);
    ack_slot(1'b0);
    fe = 1'b1; @(negedge clk); fe = 1'b0;
    wait_load("b2b_second_load", 8);
    gap = cyc - last_fe_cyc;
    chk("b2b_gap", gap, 2);
    chk("b2b_second_data", tx_data, 8'hFF);
    byte_valid = 1'b0;
    shift_bits(8);
    ack_slot(1'b0);
    fall();

    // Abort after three bits.
    a0 = n_ack; k0 = n_nack;
    byte_data = 8'h5A; byte_valid = 1'b1;
    wait_load("abort_load_seen", 8);
    byte_valid = 1'b0;
    shift_bits(3);
    abort = 1'b1; @(negedge clk); abort = 1'b0;
    chk("abort_tx_enable", tx_enable, 0);
    chk("abort_sda_oe", sda_oe, 0);
    chk("abort_ready", byte_ready, 1);
    chk("abort_tx_data_held", tx_data, 8'h5A);
    rise(); fall();
    chk("abort_no_ack", n_ack - a0, 0);
    chk("abort_no_nack", n_nack - k0, 0);

    // Edges stop in SHIFT.
    byte_data = 8'h77; byte_valid = 1'b1;
    wait_load("wd_load_seen", 8);
    byte_valid = 1'b0;
    t0 = n_to;
    repeat (40) @(negedge clk);
`ifdef TX_BYTE_CTRL_TIMEOUT_EN
    chk("wd_timeout_count", n_to - t0, 1);
    chk("wd_idle", byte_ready, 1);
`else
    chk("wd_timeout_count", n_to - t0, 0);
    chk("wd_still_shifting", tx_enable, 1);
`endif
    abort = 1'b1; @(negedge clk); abort = 1'b0;
    repeat (2) @(negedge clk);
    chk("final_idle", byte_ready, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_time_limit: bench did not complete, checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

endmodule
